// File: rtl/nn_pkg.sv
// Shared FSM state type, lane control bundle and sizing helpers for the
// layer engine and its MAC lanes.
package nn_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MAC, ACT, OUT, FIN} nn_state_e;

  typedef struct packed {
    logic clr;
    logic en;
    logic relu;
  } lane_ctrl_t;

  // Wide enough that N_UNITS full-scale products can never overflow.
  function automatic int acc_width(input int data_w, input int weight_w, input int n_units);
    return data_w + weight_w + $clog2(n_units);
  endfunction

  function automatic longint sat_hi(input int data_w);
    return (longint'(1) <<< (data_w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int data_w);
    return -(longint'(1) <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/neural_mac_lane.sv
// One neuron: signed multiply-accumulate, saturation to DATA_W and optional
// ReLU on the combinational result.
module neural_mac_lane
  import nn_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 8,
  parameter int N_UNITS  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  lane_ctrl_t                 ctrl,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [WEIGHT_W-1:0] w,
  output logic [DATA_W-1:0]          res
);
  localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, N_UNITS);
  localparam int PRD_W = DATA_W + WEIGHT_W;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(DATA_W));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(DATA_W));

  logic signed [PRD_W-1:0]  prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] sat;

  assign prod = PRD_W'(a) * PRD_W'(w);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        acc_q <= '0;
    else if (ctrl.clr) acc_q <= '0;
    else if (ctrl.en)  acc_q <= acc_q + ACC_W'(prod);
  end

  always_comb begin
    sat = acc_q[DATA_W-1:0];
    if (acc_q > HI)      sat = HI[DATA_W-1:0];
    else if (acc_q < LO) sat = LO[DATA_W-1:0];
    res = (ctrl.relu && sat[DATA_W-1]) ? '0 : sat;
  end

endmodule

// File: rtl/neural_layer_engine.sv
// Multi-layer fully-connected engine: loads an input vector, runs N_LAYERS of
// MAC + saturate/ReLU in place over the data registers, then streams results.
module neural_layer_engine
  import nn_pkg::*;
#(
  parameter int N_UNITS  = 4,
  parameter int DATA_W   = 32,
  parameter int WEIGHT_W = 8,
  parameter int N_LAYERS = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  relu_en,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_W-1:0]                     in_data,
  output logic [$clog2(N_LAYERS*N_UNITS)-1:0]   w_addr,
  input  logic [N_UNITS*WEIGHT_W-1:0]           w_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_W-1:0]                     out_data,
  output logic                                  busy,
  output logic                                  done
);
  localparam int ADDR_W = $clog2(N_LAYERS*N_UNITS);
  localparam int IDX_W  = $clog2(N_UNITS);
  localparam int LYR_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_UNITS-1);

  nn_state_e                      state;
  logic [IDX_W-1:0]               cnt, idx_q;
  logic [LYR_W-1:0]               layer;
  logic                           mac_iss, acc_vld, relu_q;
  logic [N_UNITS-1:0][DATA_W-1:0] data_q, lane_res;
  lane_ctrl_t                     lane_ctrl;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);
  assign out_data  = data_q[cnt];
  assign w_addr    = (state == MAC && mac_iss) ?
                     ADDR_W'(int'(layer) * N_UNITS + int'(cnt)) : '0;

  // Clearing in LOAD/ACT leaves the accumulators at zero on every MAC entry.
  assign lane_ctrl = '{clr: (state == LOAD || state == ACT), en: acc_vld, relu: relu_q};

  for (genvar j = 0; j < N_UNITS; j++) begin : g_lane
    neural_mac_lane #(.DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W), .N_UNITS(N_UNITS)) u_lane (
      .clk  (clk),
      .reset(reset),
      .ctrl (lane_ctrl),
      .a    (data_q[idx_q]),
      .w    (w_data[j*WEIGHT_W +: WEIGHT_W]),
      .res  (lane_res[j])
    );
  end

  // mac_iss marks the N address-issue cycles; the extra MAC cycle drains the
  // last weight row returned one cycle after its address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      layer   <= '0;
      mac_iss <= 1'b0;
      acc_vld <= 1'b0;
      relu_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      acc_vld <= (state == MAC) && mac_iss;
      idx_q   <= cnt;
      case (state)
        IDLE: if (start) begin
          state  <= LOAD;
          cnt    <= '0;
          layer  <= '0;
          relu_q <= relu_en;
        end
        LOAD: if (in_valid) begin
          data_q[cnt] <= in_data;
          cnt         <= cnt + IDX_W'(1);
          if (cnt == LAST) begin
            state   <= MAC;
            cnt     <= '0;
            mac_iss <= 1'b1;
          end
        end
        MAC: if (mac_iss) begin
          cnt <= cnt + IDX_W'(1);
          if (cnt == LAST) begin
            cnt     <= '0;
            mac_iss <= 1'b0;
          end
        end else begin
          state <= ACT;
        end
        ACT: begin
          data_q <= lane_res;
          cnt    <= '0;
          layer  <= layer + LYR_W'(1);
          if (layer == LYR_W'(N_LAYERS-1)) begin
            state <= OUT;
          end else begin
            state   <= MAC;
            mac_iss <= 1'b1;
          end
        end
        OUT: if (out_ready) begin
          if (cnt == LAST) state <= FIN;
          else             cnt   <= cnt + IDX_W'(1);
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neural_layer_engine.sv
// Directed bench for neural_layer_engine (4 units, 16-bit data, 2 layers):
// identity/ReLU/saturation/mixing weights, backpressure, reset and stray start.
module tb_neural_layer_engine;
  localparam int N = 4, DW = 16, WW = 8, NL = 2;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, relu_en = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic [2:0]      w_addr;
  logic [N*WW-1:0] w_data;
  logic            in_ready, out_valid, busy, done;
  logic [DW-1:0]   out_data;
  logic [N*WW-1:0] wmem [0:N*NL-1];

  int total = 0, bad = 0, done_cnt = 0, lat = 0;
  int xin [N];
  int res [N];
  int exp_v [N];

  neural_layer_engine #(.N_UNITS(N), .DATA_W(DW), .WEIGHT_W(WW), .N_LAYERS(NL)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_addr(w_addr), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) w_data <= wmem[w_addr];
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  function automatic logic [N*WW-1:0] mkrow(input int a, input int b, input int c, input int d);
    return {WW'(d), WW'(c), WW'(b), WW'(a)};
  endfunction

  task automatic set_identity(input int l);
    wmem[l*N+0] = mkrow(1, 0, 0, 0);
    wmem[l*N+1] = mkrow(0, 1, 0, 0);
    wmem[l*N+2] = mkrow(0, 0, 1, 0);
    wmem[l*N+3] = mkrow(0, 0, 0, 1);
  endtask

  task automatic set_all(input int l, input int v);
    for (int i = 0; i < N; i++) wmem[l*N+i] = mkrow(v, v, v, v);
  endtask

  task automatic load_vec(input bit relu);
    @(negedge clk); start = 1'b1; relu_en = relu;
    @(negedge clk); start = 1'b0; lat = 1;
    for (int n = 0; n < N; n++) begin
      chk("in_ready", int'(in_ready), 1);
      in_valid = 1'b1; in_data = DW'(xin[n]);
      @(negedge clk); lat++;
    end
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic run(input bit relu, input bit stall, input bit poke);
    int k, base;
    bit stalled;
    logic [DW-1:0] held;
    base = done_cnt; stalled = 1'b0; k = 0;
    for (int i = 0; i < N; i++) res[i] = 0;
    load_vec(relu);
    out_ready = 1'b1;
    while (!out_valid && lat < 200) begin
      start = poke && (lat == 8);
      @(negedge clk); lat++;
    end
    start = 1'b0;
    chk("out_valid_seen", int'(out_valid), 1);
    for (int g = 0; g < 100 && k < N; g++) begin
      if (out_valid) begin
        if (stall && k == 1 && !stalled) begin
          out_ready = 1'b0; held = out_data; stalled = 1'b1;
          for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_data", int'(out_data), int'(held));
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_done", int'(done), 0);
          end
          out_ready = 1'b1;
        end
        res[k] = int'($signed(out_data));
        k++;
      end
      @(negedge clk);
    end
    chk("words", k, N);
    chk("done_pulse", int'(done), 1);
    @(negedge clk); out_ready = 1'b0;
    chk("idle_busy", int'(busy), 0);
    @(negedge clk);
    chk("done_count", done_cnt - base, 1);
  endtask

  task automatic chk_res(input string tag);
    for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", tag, i), res[i], exp_v[i]);
  endtask

  initial begin
    set_identity(0); set_identity(1);
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    @(negedge clk); reset = 1'b1;

    xin = '{5, -3, 7, 0};
    run(1'b0, 1'b0, 1'b0);
    chk("lat_identity", lat, 17);
    exp_v = '{5, -3, 7, 0}; chk_res("identity");

    run(1'b1, 1'b0, 1'b0);
    exp_v = '{5, 0, 7, 0}; chk_res("relu");

    xin = '{32767, 32767, 32767, 32767};
    set_all(0, 127); set_all(1, 127);
    run(1'b0, 1'b0, 1'b0);
    exp_v = '{32767, 32767, 32767, 32767}; chk_res("sat_pos");

    set_all(0, -128); set_identity(1);
    run(1'b0, 1'b0, 1'b0);
    exp_v = '{-32768, -32768, -32768, -32768}; chk_res("sat_neg");

    // Asymmetric matrix: row i holds weights from input i to units 0..3.
    wmem[0] = mkrow(1, 0, 0, -1);
    wmem[1] = mkrow(1, 2, 0, 0);
    wmem[2] = mkrow(1, 0, 3, 0);
    wmem[3] = mkrow(1, 0, 0, 4);
    xin = '{5, -3, 7, 2};
    run(1'b0, 1'b0, 1'b0);
    exp_v = '{11, -6, 21, 3}; chk_res("mix");

    set_identity(0);
    xin = '{9, -8, 100, -1};
    run(1'b0, 1'b1, 1'b0);
    chk("lat_stall", lat, 17);
    exp_v = '{9, -8, 100, -1}; chk_res("stall");

    xin = '{5, -3, 7, 0};
    run(1'b0, 1'b0, 1'b1);
    chk("lat_poke", lat, 17);
    exp_v = '{5, -3, 7, 0}; chk_res("poke");

    load_vec(1'b0);
    repeat (7) @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    chk("mid_w_addr", int'(w_addr), 5);
    reset = 1'b0;
    #1;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_in_ready", int'(in_ready), 0);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_w_addr", int'(w_addr), 0);
    @(negedge clk); reset = 1'b1;
    xin = '{1, 2, 3, 4};
    run(1'b0, 1'b0, 1'b0);
    chk("lat_after_reset", lat, 17);
    exp_v = '{1, 2, 3, 4}; chk_res("after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
